fix_field_tokenizer: RTL

Byte-stream front end for the FIX hashing path: splits an incoming FIX message into `tag=value<SOH>` fields, decodes the decimal tag, and forwards each value's bytes to the downstream `jenkins` hasher using its `sample`/`value` protocol. After the last value byte it drops `sample` for one cycle with `value` = 0, which closes the hash. It also reports the tag, the value length and the error status of each field, so downstream logic can pair them with the hasher's `hash`/`complete`.

---
 rtl/fix_pkg.sv | 19 +
 rtl/fix_checksum.sv | 79 +++++++
 rtl/fix_field_tokenizer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fix_pkg.sv
// fix_pkg: byte constants and tokenizer state encoding shared by the
// FIX field tokenizer and its optional checksum unit.
package fix_pkg;

  localparam logic [7:0] FIX_SOH = 8'h01;
  localparam logic [7:0] FIX_EQ  = 8'h3D;
  localparam logic [7:0] ASCII_0 = 8'h30;

  typedef enum logic [1:0] {
    S_TAG,
    S_VALUE,
    S_SKIP
  } fix_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_0 + 8'd9);
  endfunction

endpackage

// File: rtl/fix_checksum.sv
// fix_checksum: mod-256 running message sum and tag-10 comparator.
// Sum is frozen at each SOH so the tag-10 field itself is excluded.
module fix_checksum
  import fix_pkg::*;
#(
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_ok,
  input  logic [7:0]       byte_in,
  input  logic             tag_set,
  input  logic [TAG_W-1:0] tag_nxt,
  input  logic             fwd,
  input  logic             fin,
  input  logic             fin_err,
  output logic             cksum_ok,
  output logic             cksum_bad
);

  logic [7:0] sum;
  logic [7:0] base;
  logic       is10;
  logic       fmt_bad;
  logic [1:0] ndig;
  logic [9:0] val;
  logic [3:0] d;
  logic       good;

  assign d = byte_in[3:0];

  assign good = !fin_err && !fmt_bad &&
                (ndig == 2'd3) &&
                (val == {2'b00, base});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      base      <= '0;
      is10      <= 1'b0;
      fmt_bad   <= 1'b0;
      ndig      <= '0;
      val       <= '0;
      cksum_ok  <= 1'b0;
      cksum_bad <= 1'b0;
    end else begin
      cksum_ok  <= 1'b0;
      cksum_bad <= 1'b0;
      if (byte_ok) begin
        sum <= sum + byte_in;
        if (byte_in == FIX_SOH)
          base <= sum + byte_in;
      end
      if (tag_set) begin
        is10    <= (tag_nxt == TAG_W'(10));
        fmt_bad <= 1'b0;
        ndig    <= '0;
        val     <= '0;
      end
      if (fwd && is10) begin
        if (is_digit(byte_in) && (ndig != 2'd3)) begin
          val  <= (val << 3) + (val << 1) + 10'(d);
          ndig <= ndig + 2'd1;
        end else begin
          fmt_bad <= 1'b1;
        end
      end
      // closing SOH of tag 10 starts the next message from zero
      if (fin && is10) begin
        cksum_ok  <= good;
        cksum_bad <= !good;
        sum       <= '0;
        base      <= '0;
        is10      <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fix_field_tokenizer.sv
// fix_field_tokenizer: splits FIX tag=value<SOH> fields and feeds values
// to the jenkins hasher. Optional checksum unit: FIX_CHECKSUM_EN.
module fix_field_tokenizer
  import fix_pkg::*;
#(
  parameter int MAX_LEN = 12,
  parameter int TAG_W   = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             sample,
  output logic [7:0]       value,
  output logic [TAG_W-1:0] tag,
  output logic             field_done,
  output logic [7:0]       field_len,
  output logic             field_err,
  output logic             cksum_ok,
  output logic             cksum_bad
);

  fix_state_e       st, st_n;
  logic [TAG_W-1:0] acc, acc_n, tag_n;
  logic             dig, dig_n;
  logic [7:0]       len, len_n;
  logic [7:0]       value_n, flen_n;
  logic             sample_n, done_n, ferr_n;
  logic             is_dig, is_eq, is_soh;
  logic [3:0]       dval;
  logic [TAG_W+3:0] wide;

  assign is_dig = is_digit(in_data);
  assign is_eq  = (in_data == FIX_EQ);
  assign is_soh = (in_data == FIX_SOH);
  assign dval   = 4'(in_data - ASCII_0);

  // four guard bits expose a tag that no longer fits TAG_W
  assign wide = ({4'd0, acc} << 3) +
                ({4'd0, acc} << 1) +
                (TAG_W+4)'(dval);

  always_comb begin
    st_n     = st;
    acc_n    = acc;
    dig_n    = dig;
    len_n    = len;
    tag_n    = tag;
    sample_n = 1'b0;
    value_n  = 8'h00;
    done_n   = 1'b0;
    flen_n   = 8'h00;
    ferr_n   = 1'b0;
    unique case (st)
      S_TAG: begin
        if (in_valid) begin
          unique case (1'b1)
            is_dig: begin
              if (|wide[TAG_W+3:TAG_W]) begin
                st_n = S_SKIP;
              end else begin
                acc_n = wide[TAG_W-1:0];
                dig_n = 1'b1;
              end
            end
            is_eq: begin
              if (dig) begin
                tag_n = acc;
                len_n = 8'h00;
                st_n  = S_VALUE;
              end else begin
                st_n = S_SKIP;
              end
            end
            is_soh: begin
              // malformed field ended before any '='
              done_n = 1'b1;
              ferr_n = 1'b1;
              acc_n  = '0;
              dig_n  = 1'b0;
              len_n  = 8'h00;
            end
            default: st_n = S_SKIP;
          endcase
        end
      end
      S_VALUE: begin
        if (!in_valid) begin
          st_n = S_SKIP;
        end else if (is_soh) begin
          done_n = 1'b1;
          flen_n = len;
          acc_n  = '0;
          dig_n  = 1'b0;
          len_n  = 8'h00;
          st_n   = S_TAG;
        end else if (len == 8'(MAX_LEN)) begin
          st_n = S_SKIP;
        end else begin
          sample_n = 1'b1;
          value_n  = in_data;
          len_n    = len + 8'd1;
        end
      end
      S_SKIP: begin
        if (in_valid && is_soh) begin
          done_n = 1'b1;
          flen_n = len;
          ferr_n = 1'b1;
          acc_n  = '0;
          dig_n  = 1'b0;
          len_n  = 8'h00;
          st_n   = S_TAG;
        end
      end
      default: st_n = S_TAG;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      st         <= S_TAG;
      acc        <= '0;
      dig        <= 1'b0;
      len        <= 8'h00;
      tag        <= '0;
      sample     <= 1'b0;
      value      <= 8'h00;
      field_done <= 1'b0;
      field_len  <= 8'h00;
      field_err  <= 1'b0;
    end else begin
      st         <= st_n;
      acc        <= acc_n;
      dig        <= dig_n;
      len        <= len_n;
      tag        <= tag_n;
      sample     <= sample_n;
      value      <= value_n;
      field_done <= done_n;
      field_len  <= flen_n;
      field_err  <= ferr_n;
    end
  end

`ifdef FIX_CHECKSUM_EN
  logic tset;

  assign tset = (st == S_TAG) && (st_n == S_VALUE);

  fix_checksum #(
    .TAG_W(TAG_W)
  ) u_ck (
    .clk      (CLOCK),
    .rst      (RESET),
    .byte_ok  (in_valid),
    .byte_in  (in_data),
    .tag_set  (tset),
    .tag_nxt  (tag_n),
    .fwd      (sample_n),
    .fin      (done_n),
    .fin_err  (ferr_n),
    .cksum_ok (cksum_ok),
    .cksum_bad(cksum_bad)
  );
`else
  assign cksum_ok  = 1'b0;
  assign cksum_bad = 1'b0;
`endif

endmodule
